bj_predict_unit: RTL and testbench
==================================

# bj_predict_unit

Parametrised branch/jump resolution unit with a built-in bimodal predictor for the RV32IM pipeline. It serves two stages:
- **IF:** a combinational taken/not-taken prediction indexed by PC.
- **EX:** resolves the actual outcome with the team's 3-bit BRANCH_JUMP encoding, trains a table of 2-bit saturating counters, and issues a registered redirect plus a flush on mispredict.

It replaces the purely combinational branch detector and adds prediction, training and wrong-path masking.

## Interface
Parameters:
- XLEN, 32, operand and PC width
- BHT_DEPTH, 64, counter-table entries; must be a power of 2 and ≥ 2
- CTR_INIT, 2'b01, counter value loaded on reset (weakly not-taken)

Ports:
- CLK  in  1  single clock; all state updates on its rising edge
- RESET  in  1  synchronous, active-high reset
- IF_PC  in  XLEN  fetch PC used for the prediction lookup
- PRED_TAKEN  out  1  combinational prediction for IF_PC (counter MSB)
- EX_VALID  in  1  a branch/jump instruction occupies EX this cycle
- EX_STALL  in  1  EX is frozen; no resolution or training this cycle
- BRANCH_JUMP  in  3  branch/jump type (encoding below)
- DATA1, DATA2  in  XLEN  rs1/rs2 operands
- EX_PC  in  XLEN  PC of the instruction in EX
- EX_TARGET  in  XLEN  computed branch/jump target
- EX_PRED_TAKEN  in  1  prediction that was made for this instruction
- PC_SEL_OUT  out  1  registered; redirect the PC to PC_TARGET_OUT
- PC_TARGET_OUT  out  XLEN  registered redirect address
- PREG_FL  out  1  registered; flush the IF/ID and ID/EX pipeline registers
- BR_COUNT, MISP_COUNT  out  32  performance counters (see Configuration)

## Operation
- **BRANCH_JUMP encoding:**
  - 000 BEQ, 001 BNE, 011 JAL/JALR, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU.
  - 010 means none; it resolves as not taken and is never a mispredict.
- **Compare widths:** all comparisons are XLEN wide. Codes 100/101 compare signed; codes 110/111 compare unsigned.
- **Table index:** IDX = IF_PC[log2(BHT_DEPTH)+1:2] for lookup and EX_PC[log2(BHT_DEPTH)+1:2] for training.
- **A resolution event** occurs when EX_VALID=1, EX_STALL=0, state=RUN, and BRANCH_JUMP≠010.
- **Actual outcome:**
  - JAL/JALR (011) is always taken.
  - Conditional branches use the compare result.
- **Mispredict:** actual ≠ EX_PRED_TAKEN.
  - Actual taken → target = EX_TARGET.
  - Actual not taken → target = EX_PC+4, modulo 2^XLEN.
- **Training:** conditional branches only; jumps never modify the table.
  - Counter increments when taken and saturates at 11.
  - Counter decrements when not taken and saturates at 00.
- **Simultaneous lookup and update of the same entry:** PRED_TAKEN shows the pre-update value (read-before-write).
- **FSM states:**
  - RUN: normal operation.
  - SHADOW: one cycle after a flush is issued.
- **FSM transitions:**
  - RUN→SHADOW on a mispredict resolution event.
  - SHADOW→RUN unconditionally after one cycle, even if EX_STALL=1.
  - In SHADOW, EX inputs are ignored: no training, no redirect, no counting. The wrong-path instruction already in EX is discarded.

## Timing
- **PRED_TAKEN:** 0-cycle latency, combinational from the flop array.
- **Redirect and flush:** PC_SEL_OUT and PREG_FL assert together for exactly 1 cycle, in the cycle after the mispredict resolution event. PC_TARGET_OUT is valid in that same cycle.
- **Correct predictions:** PC_SEL_OUT, PREG_FL and PC_TARGET_OUT hold 0.
- **Counter writes:** take effect at the edge that ends the event cycle.
- **Reset values:** PC_SEL_OUT=0, PREG_FL=0, PC_TARGET_OUT=0, state=RUN, every table entry=CTR_INIT, BR_COUNT=MISP_COUNT=0.
- **Reset mid-operation:** RESET wins over everything. A pending redirect or SHADOW cycle is dropped and no training occurs in that cycle.

## Configuration
- **BJ_PERF_CNT_EN defined:**
  - BR_COUNT increments on every resolution event.
  - MISP_COUNT increments on every mispredict.
  - Both are 32-bit and saturate at 32'hFFFFFFFF.
- **BJ_PERF_CNT_EN undefined:** no counter flops are built and BR_COUNT and MISP_COUNT are tied to 0.

## Structure
- **Package bj_pkg:**
  - Localparams for the seven BRANCH_JUMP codes plus NONE.
  - 2-bit counter constants (SNT=00, WNT=01, WT=10, ST=11).
  - FSM state encoding (RUN, SHADOW).
- **Sub-module bj_compare:** combinational only. Takes BRANCH_JUMP, DATA1 and DATA2 and returns the actual outcome. Verified standalone with the same encoding.

## Test plan
1. Reset, then BEQ with DATA1=DATA2=5, EX_PRED_TAKEN=0, EX_TARGET=0x100, EX_PC=0x40 → next cycle PC_SEL_OUT=PREG_FL=1, PC_TARGET_OUT=0x100; entry 16 goes 01→10.
2. BLT with DATA1=0xFFFFFFFF, DATA2=1, EX_PRED_TAKEN=1 → correct, no flush. BLTU with the same operands and EX_PRED_TAKEN=1 → flush with target EX_PC+4.
3. Mispredict immediately followed by EX_VALID=1 with another mispredicting branch in the SHADOW cycle → only one flush pulse, and no training for the second branch.
4. Same branch taken 4 times → counter saturates at 11. Then 2 not-taken → 01, and PRED_TAKEN=0 for that PC.
5. JAL at EX_PC=0xFFFFFFFC with EX_PRED_TAKEN=0 → flush to EX_TARGET and table unchanged. BNE not taken at the same PC with EX_PRED_TAKEN=1 → target wraps to 0x0.
6. Assert RESET in the cycle a mispredict is presented → no flush in the next cycle, all entries at CTR_INIT, counters at 0. With BJ_PERF_CNT_EN defined, 3 events including 1 mispredict → BR_COUNT=3, MISP_COUNT=1.

Source files
------------

// File: rtl/bj_predict_unit_pkg.sv
// Shared encodings for the branch/jump resolution unit: BRANCH_JUMP codes,
// 2-bit counter states, FSM states and the saturating counter update.
package bj_pkg;

  localparam logic [2:0] BJ_BEQ  = 3'b000;
  localparam logic [2:0] BJ_BNE  = 3'b001;
  localparam logic [2:0] BJ_NONE = 3'b010;
  localparam logic [2:0] BJ_JUMP = 3'b011;
  localparam logic [2:0] BJ_BLT  = 3'b100;
  localparam logic [2:0] BJ_BGE  = 3'b101;
  localparam logic [2:0] BJ_BLTU = 3'b110;
  localparam logic [2:0] BJ_BGEU = 3'b111;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_SHADOW = 1'b1
  } bj_state_e;

  function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
    logic [1:0] nxt;
    nxt = ctr;
    if (taken) begin
      if (ctr != CTR_ST) begin
        nxt = ctr + 2'd1;
      end else begin
        nxt = CTR_ST;
      end
    end else begin
      if (ctr != CTR_SNT) begin
        nxt = ctr - 2'd1;
      end else begin
        nxt = CTR_SNT;
      end
    end
    return nxt;
  endfunction

endpackage

// File: rtl/bj_predict_unit_compare.sv
// bj_compare: combinational actual-outcome evaluation for one BRANCH_JUMP code.
module bj_compare
  import bj_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      BRANCH_JUMP,
  input  logic [XLEN-1:0] DATA1,
  input  logic [XLEN-1:0] DATA2,
  output logic            TAKEN
);

  // Resolve the outcome; NONE resolves as not taken.
  always_comb begin
    TAKEN = 1'b0;
    case (BRANCH_JUMP)
      BJ_BEQ:  TAKEN = (DATA1 == DATA2);
      BJ_BNE:  TAKEN = (DATA1 != DATA2);
      BJ_JUMP: TAKEN = 1'b1;
      BJ_BLT:  TAKEN = ($signed(DATA1) <  $signed(DATA2));
      BJ_BGE:  TAKEN = ($signed(DATA1) >= $signed(DATA2));
      BJ_BLTU: TAKEN = (DATA1 <  DATA2);
      BJ_BGEU: TAKEN = (DATA1 >= DATA2);
      default: TAKEN = 1'b0;
    endcase
  end

endmodule

// File: rtl/bj_predict_unit.sv
// Branch/jump resolution with a bimodal predictor, registered redirect/flush and
// a one-cycle wrong-path SHADOW state. Optional counters: define BJ_PERF_CNT_EN.
module bj_predict_unit
  import bj_pkg::*;
#(
  parameter int         XLEN      = 32,
  parameter int         BHT_DEPTH = 64,
  parameter logic [1:0] CTR_INIT  = 2'b01
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic [XLEN-1:0] IF_PC,
  output logic            PRED_TAKEN,
  input  logic            EX_VALID,
  input  logic            EX_STALL,
  input  logic [2:0]      BRANCH_JUMP,
  input  logic [XLEN-1:0] DATA1,
  input  logic [XLEN-1:0] DATA2,
  input  logic [XLEN-1:0] EX_PC,
  input  logic [XLEN-1:0] EX_TARGET,
  input  logic            EX_PRED_TAKEN,
  output logic            PC_SEL_OUT,
  output logic [XLEN-1:0] PC_TARGET_OUT,
  output logic            PREG_FL,
  output logic [31:0]     BR_COUNT,
  output logic [31:0]     MISP_COUNT
);

  localparam int IDXW = $clog2(BHT_DEPTH);
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(32'd4);

  logic [1:0]      bht_q [BHT_DEPTH];
  logic [1:0]      bht_d [BHT_DEPTH];
  bj_state_e       state_q, state_d;
  logic            pc_sel_q, pc_sel_d;
  logic            flush_q, flush_d;
  logic [XLEN-1:0] target_q, target_d;

  logic [IDXW-1:0] if_idx, ex_idx;
  logic            actual_taken, res_event, mispredict;
  logic            unused_pc_bits;

  assign if_idx = IF_PC[IDXW+1:2];
  assign ex_idx = EX_PC[IDXW+1:2];
  assign unused_pc_bits = ^{IF_PC[XLEN-1:IDXW+2], IF_PC[1:0], EX_PC[1:0]};

  bj_compare #(.XLEN(XLEN)) u_compare (
    .BRANCH_JUMP (BRANCH_JUMP),
    .DATA1       (DATA1),
    .DATA2       (DATA2),
    .TAKEN       (actual_taken)
  );

  // Table is read from the current flops, so a same-cycle update is not visible.
  assign PRED_TAKEN = bht_q[if_idx][1];

  assign res_event  = EX_VALID && !EX_STALL && (state_q == ST_RUN) && (BRANCH_JUMP != BJ_NONE);
  assign mispredict = res_event && (actual_taken != EX_PRED_TAKEN);

  // Next-state: FSM, redirect/flush and table training.
  always_comb begin
    bht_d    = bht_q;
    state_d  = state_q;
    pc_sel_d = mispredict;
    flush_d  = mispredict;
    target_d = '0;
    if (mispredict) begin
      target_d = actual_taken ? EX_TARGET : (EX_PC + PC_STEP);
    end else begin
      target_d = '0;
    end
    if (res_event && (BRANCH_JUMP != BJ_JUMP)) begin
      bht_d[ex_idx] = ctr_next(bht_q[ex_idx], actual_taken);
    end else begin
      bht_d[ex_idx] = bht_q[ex_idx];
    end
    case (state_q)
      ST_RUN:    state_d = mispredict ? ST_SHADOW : ST_RUN;
      ST_SHADOW: state_d = ST_RUN;
      default:   state_d = ST_RUN;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= ST_RUN;
      pc_sel_q <= 1'b0;
      flush_q  <= 1'b0;
      target_q <= '0;
      for (int i = 0; i < BHT_DEPTH; i++) begin
        bht_q[i] <= CTR_INIT;
      end
    end else begin
      state_q  <= state_d;
      pc_sel_q <= pc_sel_d;
      flush_q  <= flush_d;
      target_q <= target_d;
      for (int i = 0; i < BHT_DEPTH; i++) begin
        bht_q[i] <= bht_d[i];
      end
    end
  end

  assign PC_SEL_OUT    = pc_sel_q;
  assign PREG_FL       = flush_q;
  assign PC_TARGET_OUT = target_q;

`ifdef BJ_PERF_CNT_EN
  logic [31:0] br_cnt_q, br_cnt_d;
  logic [31:0] misp_cnt_q, misp_cnt_d;

  // Saturating event counters.
  always_comb begin
    br_cnt_d   = br_cnt_q;
    misp_cnt_d = misp_cnt_q;
    if (res_event && (br_cnt_q != 32'hFFFF_FFFF)) begin
      br_cnt_d = br_cnt_q + 32'd1;
    end else begin
      br_cnt_d = br_cnt_q;
    end
    if (mispredict && (misp_cnt_q != 32'hFFFF_FFFF)) begin
      misp_cnt_d = misp_cnt_q + 32'd1;
    end else begin
      misp_cnt_d = misp_cnt_q;
    end
  end

  // Counter registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      br_cnt_q   <= 32'd0;
      misp_cnt_q <= 32'd0;
    end else begin
      br_cnt_q   <= br_cnt_d;
      misp_cnt_q <= misp_cnt_d;
    end
  end

  assign BR_COUNT   = br_cnt_q;
  assign MISP_COUNT = misp_cnt_q;
`else
  assign BR_COUNT   = 32'd0;
  assign MISP_COUNT = 32'd0;
`endif

endmodule

// File: tb/tb_bj_predict_unit.sv
// Scoreboard bench for bj_predict_unit: expected flushes are queued with the cycle
// they must appear in; a negedge monitor checks every cycle's redirect outputs.
module tb_bj_predict_unit;
  import bj_pkg::*;

  logic        clk;
  logic        reset;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic        ex_valid, ex_stall, ex_pred_taken;
  logic [2:0]  branch_jump;
  logic [31:0] data1, data2, ex_pc, ex_target;
  logic        pc_sel_out, preg_fl;
  logic [31:0] pc_target_out, br_count, misp_count;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  logic mon_en = 1'b0;

  typedef struct {
    int          at;
    logic [31:0] tgt;
    string       nm;
  } exp_t;
  exp_t exp_q[$];

  bj_predict_unit #(.XLEN(32), .BHT_DEPTH(64), .CTR_INIT(2'b01)) dut (
    .CLK(clk), .RESET(reset), .IF_PC(if_pc), .PRED_TAKEN(pred_taken),
    .EX_VALID(ex_valid), .EX_STALL(ex_stall), .BRANCH_JUMP(branch_jump),
    .DATA1(data1), .DATA2(data2), .EX_PC(ex_pc), .EX_TARGET(ex_target),
    .EX_PRED_TAKEN(ex_pred_taken), .PC_SEL_OUT(pc_sel_out),
    .PC_TARGET_OUT(pc_target_out), .PREG_FL(preg_fl),
    .BR_COUNT(br_count), .MISP_COUNT(misp_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every cycle either a queued flush is due or outputs must be idle.
  always @(negedge clk) begin
    if (mon_en) begin
      if (exp_q.size() > 0 && exp_q[0].at < cyc) begin
        tests++; fails++;
        $display("FAIL %s: flush missing, expected target %h", exp_q[0].nm, exp_q[0].tgt);
        void'(exp_q.pop_front());
      end else if (exp_q.size() > 0 && exp_q[0].at == cyc) begin
        exp_t e;
        e = exp_q.pop_front();
        tests++;
        if (pc_sel_out !== 1'b1 || preg_fl !== 1'b1 || pc_target_out !== e.tgt) begin
          fails++;
          $display("FAIL %s: sel=%b fl=%b tgt=%h, required sel=1 fl=1 tgt=%h",
                   e.nm, pc_sel_out, preg_fl, pc_target_out, e.tgt);
        end
      end else begin
        tests++;
        if (pc_sel_out !== 1'b0 || preg_fl !== 1'b0 || pc_target_out !== 32'd0) begin
          fails++;
          $display("FAIL idle_cycle_%0d: sel=%b fl=%b tgt=%h, required all 0",
                   cyc, pc_sel_out, preg_fl, pc_target_out);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ex(input logic [2:0] bj, input logic [31:0] d1, input logic [31:0] d2,
                    input logic [31:0] pc, input logic [31:0] tgt, input logic pt,
                    input logic stall, input logic flush, input logic [31:0] exp_tgt,
                    input string nm);
    if (flush) exp_q.push_back('{cyc + 1, exp_tgt, nm});
    ex_valid = 1'b1; ex_stall = stall; branch_jump = bj;
    data1 = d1; data2 = d2; ex_pc = pc; ex_target = tgt; ex_pred_taken = pt;
    @(posedge clk);
    #1;
    ex_valid = 1'b0; ex_stall = 1'b0;
  endtask

  task automatic chk_pred(input logic [31:0] pc, input logic exp, input string nm);
    if_pc = pc;
    #1;
    tests++;
    if (pred_taken !== exp) begin
      fails++;
      $display("FAIL %s: PRED_TAKEN=%b, required %b", nm, pred_taken, exp);
    end
  endtask

  task automatic chk_cnt(input logic [31:0] br, input logic [31:0] mp, input string nm);
    tests++;
    if (br_count !== br || misp_count !== mp) begin
      fails++;
      $display("FAIL %s: BR=%0d MISP=%0d, required BR=%0d MISP=%0d", nm, br_count, misp_count, br, mp);
    end
  endtask

  initial begin
    reset = 1'b1; if_pc = 32'd0; ex_valid = 1'b0; ex_stall = 1'b0; ex_pred_taken = 1'b0;
    branch_jump = BJ_NONE; data1 = 32'd0; data2 = 32'd0; ex_pc = 32'd0; ex_target = 32'd0;
    idle(2);
    reset = 1'b0;
    mon_en = 1'b1;
    chk_pred(32'h40, 1'b0, "reset_pred_0x40");
    chk_pred(32'hFC, 1'b0, "reset_pred_0xFC");
    chk_cnt(32'd0, 32'd0, "reset_counters");

    // 1: BEQ taken, predicted not taken
    ex(BJ_BEQ, 32'd5, 32'd5, 32'h40, 32'h100, 1'b0, 1'b0, 1'b1, 32'h100, "beq_misp");
    idle(1);
    chk_pred(32'h40, 1'b1, "entry16_trained_up");
    chk_pred(32'h44, 1'b0, "entry17_untouched");

    // 2: BLT signed taken (correct), BLTU unsigned not taken (mispredict)
    ex(BJ_BLT, 32'hFFFF_FFFF, 32'd1, 32'h80, 32'h500, 1'b1, 1'b0, 1'b0, 32'd0, "blt_ok");
    chk_pred(32'h80, 1'b1, "entry32_after_blt");
    ex(BJ_BLTU, 32'hFFFF_FFFF, 32'd1, 32'h80, 32'h500, 1'b1, 1'b0, 1'b1, 32'h84, "bltu_misp");
    idle(1);
    chk_pred(32'h80, 1'b0, "entry32_after_bltu");

    // 3: mispredict, then a mispredicting branch in the SHADOW cycle
    ex(BJ_BEQ, 32'd1, 32'd2, 32'hC0, 32'h600, 1'b1, 1'b0, 1'b1, 32'hC4, "shadow_first");
    ex(BJ_BNE, 32'd1, 32'd2, 32'h100, 32'h700, 1'b0, 1'b0, 1'b0, 32'd0, "shadow_second");
    chk_pred(32'h100, 1'b0, "shadow_no_train");
    ex(BJ_BEQ, 32'd3, 32'd3, 32'h100, 32'h700, 1'b1, 1'b0, 1'b0, 32'd0, "run_resumed");
    chk_pred(32'h100, 1'b1, "run_resumed_train");

    // 4: saturation at 11, then two not-taken
    for (int i = 0; i < 4; i++) begin
      ex(BJ_BEQ, 32'd7, 32'd7, 32'h20, 32'h800, 1'b1, 1'b0, 1'b0, 32'd0, "sat_taken");
      chk_pred(32'h20, 1'b1, $sformatf("sat_taken_%0d", i));
    end
    ex(BJ_BNE, 32'd7, 32'd7, 32'h20, 32'h800, 1'b0, 1'b0, 1'b0, 32'd0, "sat_nt1");
    chk_pred(32'h20, 1'b1, "sat_nt1_is_10");
    ex(BJ_BNE, 32'd7, 32'd7, 32'h20, 32'h800, 1'b0, 1'b0, 1'b0, 32'd0, "sat_nt2");
    chk_pred(32'h20, 1'b0, "sat_nt2_is_01");

    // 5: JAL at the top of memory, then BNE not taken wrapping PC+4
    ex(BJ_JUMP, 32'd0, 32'd0, 32'hFFFF_FFFC, 32'h200, 1'b0, 1'b0, 1'b1, 32'h200, "jal_misp");
    idle(1);
    chk_pred(32'hFFFF_FFFC, 1'b0, "jal_no_train");
    ex(BJ_BNE, 32'd9, 32'd9, 32'hFFFF_FFFC, 32'h200, 1'b1, 1'b0, 1'b1, 32'h0, "bne_wrap");
    idle(1);

    // NONE never mispredicts; a stalled mispredict does nothing
    ex(BJ_NONE, 32'd0, 32'd0, 32'h10, 32'h900, 1'b1, 1'b0, 1'b0, 32'd0, "none_code");
    ex(BJ_BEQ, 32'd5, 32'd5, 32'h10, 32'h900, 1'b0, 1'b1, 1'b0, 32'd0, "stalled");
    chk_pred(32'h10, 1'b0, "stall_no_train");

    // 6: reset in the cycle a mispredict is presented
    reset = 1'b1;
    ex(BJ_BEQ, 32'd5, 32'd5, 32'h40, 32'h100, 1'b0, 1'b0, 1'b0, 32'd0, "reset_drops");
    reset = 1'b0;
    idle(1);
    chk_pred(32'h40, 1'b0, "reset_entry16");
    chk_pred(32'h100, 1'b0, "reset_entry0");
    chk_cnt(32'd0, 32'd0, "reset_mid_counters");
    ex(BJ_BEQ, 32'd1, 32'd1, 32'h300, 32'hA00, 1'b1, 1'b0, 1'b0, 32'd0, "perf_ev1");
    ex(BJ_BNE, 32'd1, 32'd1, 32'h300, 32'hA00, 1'b0, 1'b0, 1'b0, 32'd0, "perf_ev2");
    ex(BJ_BLT, 32'd1, 32'd2, 32'h304, 32'h400, 1'b0, 1'b0, 1'b1, 32'h400, "perf_ev3");
    idle(2);
`ifdef BJ_PERF_CNT_EN
    chk_cnt(32'd3, 32'd1, "perf_counts");
`else
    chk_cnt(32'd0, 32'd0, "perf_tied_zero");
`endif

    idle(3);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL leftover_expect: %0d queued flushes never seen, required 0", exp_q.size());
    end
    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
